// File: rtl/bcd_hex_driver_param_if.sv
// Bundles the value/update request and the display result of
// bcd_hex_driver_param.
//   master : drives number_in / update, observes the result signals
//   slave  : the driver itself
interface bcd_hex_driver_param_if #(
   parameter int IN_WIDTH   = 20,
   parameter int NUM_DIGITS = 6
);
   logic [IN_WIDTH-1:0]     number_in;
   logic                    update;
   logic [4*NUM_DIGITS-1:0] digits_out;
   logic                    driver_ready;
   logic                    overflow;
   logic                    update_dropped;

   modport master (
      output number_in, update,
      input  digits_out, driver_ready, overflow, update_dropped
   );

   modport slave (
      input  number_in, update,
      output digits_out, driver_ready, overflow, update_dropped
   );
endinterface

// File: rtl/bcd_hex_driver_param.sv
// Binary to display-digit driver. Converts an IN_WIDTH-bit value (unsigned or
// two's complement) into NUM_DIGITS 4-bit codes with a one-bit-per-clock
// shift-add-3 engine, then formats the result. Codes: 0-9 decimal, A blank,
// B minus.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of bcd_hex_driver_param_if
//            number_in/update in, digits_out/driver_ready/overflow/
//            update_dropped out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | result valid, waiting for update
// S_CONVERT | shift-add-3 iterations, down-counter from IN_WIDTH to 0
// S_FORMAT  | saturate, blank, place minus; publish digits and overflow
module bcd_hex_driver_param #(
   parameter int IN_WIDTH      = 20,
   parameter int NUM_DIGITS    = 6,
   parameter int SIGNED_MODE   = 0,
   parameter int BLANK_LEADING = 1
) (
   input logic                    clk,
   input logic                    reset,
   bcd_hex_driver_param_if.slave  bus
);

   // ceil(IN_WIDTH*log10(2)) + 1, in integer arithmetic
   localparam int INT_DIGITS = (IN_WIDTH * 30103 + 99999) / 100000 + 1;
   localparam int BCD_W      = 4 * INT_DIGITS;
   localparam int AV         = (SIGNED_MODE != 0) ? NUM_DIGITS - 1 : NUM_DIGITS;
   localparam int MAXD       = (INT_DIGITS > NUM_DIGITS) ? INT_DIGITS : NUM_DIGITS;
   localparam int CNT_W      = $clog2(IN_WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_FORMAT} state_t;

   state_t                  r_state, w_state_nxt;
   logic [IN_WIDTH-1:0]     r_bin;
   logic [BCD_W-1:0]        r_bcd;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_neg;
   logic [4*NUM_DIGITS-1:0] r_digits;
   logic                    r_ovf;
   logic                    r_dropped;

   logic                    w_accept;
   logic                    w_in_neg;
   logic [IN_WIDTH-1:0]     w_in_mag;
   logic [4*MAXD-1:0]       w_ext;
   logic [4*NUM_DIGITS-1:0] w_fmt_digits;
   logic                    w_fmt_ovf;
   logic [3:0]              w_d;
   int                      w_msd;

   function automatic logic [BCD_W-1:0] f_add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < INT_DIGITS; i++)
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      return r;
   endfunction

   assign w_accept = (r_state == S_IDLE) && bus.update;
   assign w_in_neg = (SIGNED_MODE != 0) && bus.number_in[IN_WIDTH-1];
   // The magnitude of the most negative value is 2^(IN_WIDTH-1), which still
   // fits in IN_WIDTH unsigned bits, so an IN_WIDTH-bit negate is exact.
   assign w_in_mag = w_in_neg ? (~bus.number_in + IN_WIDTH'(1)) : bus.number_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_accept) w_state_nxt = S_CONVERT;
         S_CONVERT: if (r_cnt == '0) w_state_nxt = S_FORMAT;
         S_FORMAT:  w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bin     <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_digits  <= '0;
         r_ovf     <= 1'b0;
         r_dropped <= 1'b0;
      end else begin
         r_dropped <= bus.update && (r_state != S_IDLE);
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_bin <= w_in_mag;
               r_neg <= w_in_neg;
               r_bcd <= '0;
               r_cnt <= CNT_W'(IN_WIDTH);
            end
            S_CONVERT: if (r_cnt != '0) begin
               {r_bcd, r_bin} <= {f_add3(r_bcd), r_bin} << 1;
               r_cnt          <= r_cnt - 1'b1;
            end
            S_FORMAT: begin
               r_digits <= w_fmt_digits;
               r_ovf    <= w_fmt_ovf;
            end
            default: ;
         endcase
      end
   end

   // Formatting of the finished BCD register. w_ext zero-pads the internal
   // digits so that display slots beyond INT_DIGITS read as zero.
   always_comb begin
      w_ext              = '0;
      w_ext[BCD_W-1:0]   = r_bcd;
      w_fmt_ovf          = 1'b0;
      for (int i = AV; i < MAXD; i++)
         if (w_ext[4*i +: 4] != 4'd0) w_fmt_ovf = 1'b1;
      w_msd = 0;
      for (int i = 0; i < AV; i++)
         if (w_ext[4*i +: 4] != 4'd0) w_msd = i;
      if (w_fmt_ovf) w_msd = AV - 1;
      w_fmt_digits = '0;
      w_d          = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i < AV) w_d = w_fmt_ovf ? 4'd9 : w_ext[4*i +: 4];
         else        w_d = 4'd0;
         // w_msd >= 0, so digit 0 is never blanked
         if (BLANK_LEADING != 0 && i > w_msd) w_d = 4'hA;
         if (r_neg && i == ((BLANK_LEADING != 0) ? w_msd + 1 : NUM_DIGITS - 1))
            w_d = 4'hB;
         w_fmt_digits[4*i +: 4] = w_d;
      end
   end

   always_comb begin
      bus.driver_ready   = (r_state == S_IDLE);
      bus.digits_out     = r_digits;
      bus.overflow       = r_ovf;
      bus.update_dropped = r_dropped;
   end

endmodule

// File: doc/bcd_hex_driver_param.md
Name: bcd_hex_driver_param

Overview:
Parametrised successor of the six-digit hex/BCD display driver. Converts an IN_WIDTH-bit binary value, unsigned or two's-complement, into NUM_DIGITS 4-bit display codes using a sequential shift-add-3 (double-dabble) engine, one bit per clock. Adds optional leading-zero blanking, a minus sign, overflow saturation and dropped-update reporting. Sits between the accelerometer scaling logic and the per-digit 7-segment encoders.

Parameters:
IN_WIDTH, 20, width of number_in
NUM_DIGITS, 6, number of display digits (>=2)
SIGNED_MODE, 0, 1 = number_in is two's complement
BLANK_LEADING, 1, 1 = leading zeros are shown as blank

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
number_in  in  IN_WIDTH  value to display; sampled on an accepted update
update  in  1  single-cycle request to convert number_in
digits_out  out  4*NUM_DIGITS  digit codes, digit 0 (least significant) in bits [3:0]; 0-9 = decimal, 4'hA = blank, 4'hB = minus
driver_ready  out  1  high when idle and digits_out is valid
overflow  out  1  last displayed value did not fit; held until the next result
update_dropped  out  1  one-cycle pulse: update arrived while busy

Behaviour:
- Reset (reset low, async): state IDLE; digits_out all 4'h0; driver_ready=1; overflow=0; update_dropped=0. Reset mid-conversion aborts the conversion. No output is written.
- States: IDLE, CONVERT, FORMAT.
- IDLE: update=1 at edge k latches number_in. In signed mode it latches the magnitude (negation of a negative value in IN_WIDTH+1 bits) and a neg flag. driver_ready goes 0 after edge k. Next state is CONVERT with bit counter = IN_WIDTH.
- CONVERT: one double-dabble iteration per cycle. Before each shift, every internal BCD digit >=5 gets +3. Then shift {bcd, bin} left by 1. The internal BCD register holds INT_DIGITS = ceil(IN_WIDTH*0.30103)+1 digits. After IN_WIDTH iterations, go to FORMAT.
- FORMAT (single cycle):
  - Available magnitude digits: AV = NUM_DIGITS-1 if SIGNED_MODE, else NUM_DIGITS.
  - If any internal digit at index >=AV is nonzero: overflow=1 and the magnitude digits saturate to 9.
  - Blanking: if BLANK_LEADING, zeros above the most significant nonzero digit become 4'hA. Digit 0 is never blanked, so the value 0 shows "0".
  - Minus: if neg, 4'hB goes in the slot directly left of the most significant shown digit when BLANK_LEADING=1, otherwise in digit NUM_DIGITS-1. Remaining slots above AV are blank (BLANK_LEADING=1) or 0.
  - digits_out and overflow update atomically. driver_ready=1 after this edge.
  - Latency: driver_ready rises IN_WIDTH+2 edges after the accepting edge.
- digits_out is stable and holds the previous result throughout CONVERT and FORMAT; it never shows partial values.
- update while driver_ready=0: ignored, and update_dropped pulses for exactly one cycle. In-flight conversion is unaffected.
- update in the same cycle driver_ready rises: not accepted; dropped (pulse).
- Back-to-back: update in the first cycle driver_ready=1 is accepted normally.
- Signed most-negative input (e.g. -524288 for 20 bits): magnitude 524288 converts correctly, then the overflow rule applies.
- number_in changing outside the accepting edge has no effect.

Test Plan:
Defaults shown as HEX5..HEX0, "_" = blank, "-" = minus.
- Reset held 40 cycles, released -> driver_ready=1, digits_out=24'h000000, overflow=0.
- Defaults, number_in=55, update pulse -> driver_ready rises 22 edges later; digits "____55"; overflow=0. Then 123456 -> "123456". Then 101010 -> "101010". Then 0 -> "_____0".
- Defaults, 999999 -> "999999", overflow=0; then 1048575 -> "999999", overflow=1; then 7 -> "_____7", overflow=0.
- SIGNED_MODE=1: -42 (20'hFFFD6) -> "___-42"; -524288 -> "-99999", overflow=1; 99999 -> "_99999".
- BLANK_LEADING=0, SIGNED_MODE=1: -42 -> "-00042"; unsigned build with 55 -> "000055".
- Update at cycle 5 of a conversion -> update_dropped high for one cycle, first result is unchanged, no second conversion. Reset asserted at cycle 10 of a conversion -> immediate return to reset values; next update converts correctly.
